// File: rtl/oc8051_loader_pkg.sv
// oc8051_loader_pkg: parser state encoding and default record start marker shared by the loader
package oc8051_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR_H = 4'd1,
    S_ADDR_L = 4'd2,
    S_LEN_H  = 4'd3,
    S_LEN_L  = 4'd4,
    S_DATA   = 4'd5,
    S_CSUM   = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
endpackage

// File: rtl/oc8051_uart_rx.sv
// oc8051_uart_rx: 8N1 receiver, 16x oversampled; in clk,rst,rxd; out rx_byte, rx_valid (good stop), rx_ferr (stop=0)
module oc8051_uart_rx #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rstate_t;
  rstate_t st_q, st_d;
  logic [2:0] sync_q, sync_d;
  logic [15:0] div_q, div_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s, tick, samp;
  assign rx_s = sync_q[1];
  assign tick = div_q == 16'(CLK_DIV - 1);
  assign samp = tick && tcnt_q == 4'd7;
  assign rx_byte = sh_q;
  assign rx_valid = valid_q;
  assign rx_ferr = ferr_q;
  always_comb begin
    sync_d = {sync_q[1:0], rxd};
    div_d = tick ? '0 : div_q + 16'd1;
    tcnt_d = tick ? tcnt_q + 4'd1 : tcnt_q;
    st_d = st_q;
    bit_d = bit_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      R_IDLE: begin
        div_d = '0;
        tcnt_d = '0;
        if (sync_q[2] && !rx_s) st_d = R_START;
      end
      R_START: if (samp) st_d = rx_s ? R_IDLE : R_DATA;
      R_DATA: if (samp) begin
        sh_d = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        st_d = bit_q == 3'd7 ? R_STOP : R_DATA;
      end
      R_STOP: if (samp) begin
        valid_d = rx_s;
        ferr_d = !rx_s;
        st_d = rx_s ? R_IDLE : R_WAIT;
      end
      default: st_d = rx_s ? R_IDLE : R_WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= R_IDLE;
      sync_q <= '0;
      div_q <= '0;
      tcnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sync_q <= sync_d;
      div_q <= div_d;
      tcnt_q <= tcnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
endmodule

// File: rtl/oc8051_rom_loader.sv
// oc8051_rom_loader: serial record loader; in clk,rst,rxd; out wr_en/wr_addr/wr_data program write port, core_hold, busy, done, err
module oc8051_rom_loader
  import oc8051_loader_pkg::*;
#(
  parameter int         CLK_DIV   = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_ferr;
  oc8051_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ferr(rx_ferr)
  );
  state_t st_q, st_d;
  logic [15:0] addr_q, addr_d, cnt_q, cnt_d, wr_addr_q, wr_addr_d, len_w;
  logic [7:0] sum_q, sum_d, wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, hold_q, hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d, ok;
  assign len_w = {cnt_q[15:8], rx_byte};
  assign ok = rx_byte == sum_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign core_hold = hold_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  always_comb begin
    st_d = st_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
    if (rx_ferr && busy_q) begin
      st_d = S_ERR;
      hold_d = 1'b1;
      done_d = 1'b0;
      err_d = 1'b1;
    end else if (rx_valid) begin
      case (st_q)
        S_IDLE, S_DONE, S_ERR: if (rx_byte == SYNC_BYTE) begin
          st_d = S_ADDR_H;
          hold_d = 1'b1;
          done_d = 1'b0;
          err_d = 1'b0;
        end
        S_ADDR_H: begin
          addr_d = {rx_byte, addr_q[7:0]};
          st_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d = {addr_q[15:8], rx_byte};
          st_d = S_LEN_H;
        end
        S_LEN_H: begin
          cnt_d = {rx_byte, cnt_q[7:0]};
          st_d = S_LEN_L;
        end
        S_LEN_L: begin
          cnt_d = len_w;
          sum_d = '0;
          st_d = len_w == '0 ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          wr_en_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_byte;
          sum_d = sum_q + rx_byte;
          addr_d = addr_q + 16'd1;
          cnt_d = cnt_q - 16'd1;
          st_d = cnt_q == 16'd1 ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          st_d = ok ? S_DONE : S_ERR;
          done_d = ok;
          err_d = !ok;
          hold_d = !ok;
        end
        default: st_d = S_IDLE;
      endcase
    end
    busy_d = !(st_d inside {S_IDLE, S_DONE, S_ERR});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule
